// File: rtl/nib_rr_arbiter.sv
// Shared-bus NIB arbiter: round-robin grant with bounded burst, address-field
// slave decode with error reporting, and one-cycle registered response routing.
module nib_rr_arbiter #(
  parameter int              NUM_MASTERS = 4,
  parameter int              NUM_SLAVES  = 3,
  parameter int              AW          = 32,
  parameter int              DW          = 32,
  parameter int              SEL_LSB     = 12,
  parameter int              SEL_W       = 2,
  parameter int              MAX_BURST   = 4,
  parameter logic [DW-1:0]   ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NUM_MASTERS-1:0]              m_req_i,
  input  logic [NUM_MASTERS-1:0][AW-1:0]      m_addr_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS-1:0][DW-1:0]      m_wdata_i,
  output logic [NUM_MASTERS-1:0]              m_hold_o,
  output logic [NUM_MASTERS-1:0][DW-1:0]      m_rd_data_o,
  output logic [NUM_MASTERS-1:0]              m_rd_valid_o,
  output logic [NUM_MASTERS-1:0]              m_err_o,
  output logic [NUM_SLAVES-1:0]               s_req_o,
  output logic [AW-1:0]                       s_addr_o,
  output logic [NUM_SLAVES-1:0]               s_we_o,
  output logic [DW-1:0]                       s_wdata_o,
  input  logic [NUM_SLAVES-1:0][DW-1:0]       s_rd_data_i
);

  localparam int MW = $clog2(NUM_MASTERS);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t            state_q, state_next;
  logic [MW-1:0]     owner_q, owner_next;
  logic [MW-1:0]     rr_ptr_q, rr_ptr_next;
  logic [CW-1:0]     burst_cnt_q, burst_cnt_next;

  logic              rsp_valid_q;
  logic [MW-1:0]     rsp_master_q;
  logic [SEL_W-1:0]  rsp_slave_q;
  logic              rsp_err_q;

  logic [NUM_MASTERS-1:0] owner_mask;
  logic              keep_owner;
  logic              grant_valid;
  logic [MW-1:0]     grant_idx;
  logic              scan_found;
  int                scan_idx;
  logic [SEL_W-1:0]  sel;
  logic              sel_hit;
  logic [DW-1:0]     slave_rd_data;
  logic [DW-1:0]     rsp_data;

  // One-hot mask of the current owner (empty when idle)
  always_comb begin
    owner_mask = '0;
    if (state_q == OWNED) owner_mask[owner_q] = 1'b1;
  end

  // The owner keeps the bus while it still requests, unless its burst is used
  // up and someone else is waiting. Nothing is granted while in reset.
  assign keep_owner = rstn && (state_q == OWNED) && (|(m_req_i & owner_mask)) &&
                      ((burst_cnt_q < CNT_MAX) || !(|(m_req_i & ~owner_mask)));

  // Grant: keep owner, else first requester scanning from rr_ptr_q with wrap
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_found  = 1'b0;
    scan_idx    = 0;
    if (keep_owner) begin
      grant_valid = 1'b1;
      grant_idx   = owner_q;
    end else if (rstn) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        scan_idx = int'(rr_ptr_q) + k;
        if (scan_idx >= NUM_MASTERS) scan_idx = scan_idx - NUM_MASTERS;
        if (!scan_found && m_req_i[scan_idx]) begin
          scan_found  = 1'b1;
          grant_valid = 1'b1;
          grant_idx   = MW'(scan_idx);
        end
      end
    end
  end

  // FSM next state: ownership, round-robin pointer and burst length
  always_comb begin
    state_next     = IDLE;
    owner_next     = '0;
    rr_ptr_next    = rr_ptr_q;
    burst_cnt_next = '0;
    if (grant_valid) begin
      state_next  = OWNED;
      owner_next  = grant_idx;
      rr_ptr_next = (grant_idx == MW'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
      if ((state_q == OWNED) && (grant_idx == owner_q))
        burst_cnt_next = (burst_cnt_q == CNT_MAX) ? CNT_MAX : burst_cnt_q + 1'b1;
    end
  end

  // State and response registers; a reset drops any pending response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      burst_cnt_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_master_q <= '0;
      rsp_slave_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q     <= state_next;
      owner_q     <= owner_next;
      rr_ptr_q    <= rr_ptr_next;
      burst_cnt_q <= burst_cnt_next;
      rsp_valid_q <= grant_valid;
      if (grant_valid) begin
        rsp_master_q <= grant_idx;
        rsp_slave_q  <= sel;
        rsp_err_q    <= !sel_hit;
      end
    end
  end

  // Slave decode from the granted master's address field
  assign sel       = m_addr_i[grant_idx][SEL_LSB +: SEL_W];
  assign sel_hit   = grant_valid && (int'(sel) < NUM_SLAVES);
  assign s_addr_o  = grant_valid ? m_addr_i[grant_idx]  : '0;
  assign s_wdata_o = grant_valid ? m_wdata_i[grant_idx] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign s_req_o[gi] = sel_hit && (sel == SEL_W'(gi));
      assign s_we_o[gi]  = s_req_o[gi] && m_we_i[grant_idx];
    end
  endgenerate

  // Read-data mux driven only by registered routing state
  always_comb begin
    slave_rd_data = '0;
    for (int s = 0; s < NUM_SLAVES; s++)
      if (rsp_slave_q == SEL_W'(s)) slave_rd_data = s_rd_data_i[s];
  end

  assign rsp_data = rsp_err_q ? ERR_DATA : slave_rd_data;

  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign m_hold_o[gi]     = rstn && m_req_i[gi] && !(grant_valid && (grant_idx == MW'(gi)));
      assign m_rd_valid_o[gi] = rsp_valid_q && (rsp_master_q == MW'(gi));
      assign m_err_o[gi]      = m_rd_valid_o[gi] && rsp_err_q;
      assign m_rd_data_o[gi]  = m_rd_valid_o[gi] ? rsp_data : '0;
    end
  endgenerate

endmodule

// File: tb/tb_nib_rr_arbiter.sv
// Self-checking bench for nib_rr_arbiter: directed scenarios plus random
// traffic, compared every cycle against a behavioural arbitration model.
module tb_nib_rr_arbiter;

  localparam int NM = 4;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SEL_LSB = 12;
  localparam int SEL_W = 2;
  localparam int MAX_BURST = 4;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic [NM-1:0]            m_req_i;
  logic [NM-1:0][AW-1:0]    m_addr_i;
  logic [NM-1:0]            m_we_i;
  logic [NM-1:0][DW-1:0]    m_wdata_i;
  logic [NM-1:0]            m_hold_o;
  logic [NM-1:0][DW-1:0]    m_rd_data_o;
  logic [NM-1:0]            m_rd_valid_o;
  logic [NM-1:0]            m_err_o;
  logic [NS-1:0]            s_req_o;
  logic [AW-1:0]            s_addr_o;
  logic [NS-1:0]            s_we_o;
  logic [DW-1:0]            s_wdata_o;
  logic [NS-1:0][DW-1:0]    s_rd_data_i;

  nib_rr_arbiter #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .AW(AW), .DW(DW),
    .SEL_LSB(SEL_LSB), .SEL_W(SEL_W), .MAX_BURST(MAX_BURST), .ERR_DATA(ERR_WORD)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_wdata_i(m_wdata_i),
    .m_hold_o(m_hold_o), .m_rd_data_o(m_rd_data_o), .m_rd_valid_o(m_rd_valid_o),
    .m_err_o(m_err_o), .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_wdata_o(s_wdata_o), .s_rd_data_i(s_rd_data_i)
  );

  always #5 clk = ~clk;

  // Slave model: each slave returns a word derived from the address it saw
  // on the previous cycle.
  logic [AW-1:0] last_addr = '0;
  always @(posedge clk) last_addr <= s_addr_o;

  function automatic logic [31:0] slave_word(input int s, input logic [31:0] a);
    logic [31:0] k;
    k = 32'h1111_1111 * (s + 1);
    return a ^ k;
  endfunction

  always_comb begin
    for (int s = 0; s < NS; s++) s_rd_data_i[s] = slave_word(s, last_addr);
  end

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  int          mdl_owner = -1;
  int          mdl_ptr = 0;
  int          mdl_run = 0;
  bit          p_valid = 0;
  int          p_master = 0;
  bit          p_err = 0;
  int          p_slave = 0;
  logic [31:0] p_addr = '0;
  logic [NM-1:0] last_hold;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict, compare mid-cycle, advance the model at the edge
  task automatic step();
    int g;
    bit others;
    int sel;
    bit hit;
    logic [NM-1:0]         e_hold, e_valid, e_err;
    logic [NS-1:0]         e_sreq, e_swe;
    logic [31:0]           e_saddr, e_swdata;
    logic [NM-1:0][31:0]   e_rd;
    g = -1;
    if (rstn) begin
      others = 0;
      for (int j = 0; j < NM; j++) if (j != mdl_owner && m_req_i[j]) others = 1;
      if (mdl_owner >= 0 && m_req_i[mdl_owner] && (mdl_run < MAX_BURST || !others))
        g = mdl_owner;
      else
        for (int k = 0; k < NM; k++)
          if (g < 0 && m_req_i[(mdl_ptr + k) % NM]) g = (mdl_ptr + k) % NM;
    end
    e_hold = '0; e_sreq = '0; e_swe = '0; e_saddr = '0; e_swdata = '0;
    sel = 0; hit = 0;
    if (rstn) begin
      e_hold = m_req_i;
      if (g >= 0) e_hold[g] = 1'b0;
    end
    if (g >= 0) begin
      sel = int'(m_addr_i[g][SEL_LSB +: SEL_W]);
      hit = sel < NS;
      e_saddr = m_addr_i[g];
      e_swdata = m_wdata_i[g];
      if (hit) begin
        e_sreq[sel] = 1'b1;
        e_swe[sel] = m_we_i[g];
      end
    end
    e_valid = '0; e_err = '0; e_rd = '0;
    if (p_valid && rstn) begin
      e_valid[p_master] = 1'b1;
      e_err[p_master] = p_err;
      e_rd[p_master] = p_err ? ERR_WORD : slave_word(p_slave, p_addr);
    end
    @(negedge clk);
    chk("m_hold_o", 128'(m_hold_o), 128'(e_hold));
    chk("s_req_o", 128'(s_req_o), 128'(e_sreq));
    chk("s_we_o", 128'(s_we_o), 128'(e_swe));
    chk("s_addr_o", 128'(s_addr_o), 128'(e_saddr));
    chk("s_wdata_o", 128'(s_wdata_o), 128'(e_swdata));
    chk("m_rd_valid_o", 128'(m_rd_valid_o), 128'(e_valid));
    chk("m_err_o", 128'(m_err_o), 128'(e_err));
    chk("m_rd_data_o", 128'(m_rd_data_o), 128'(e_rd));
    last_hold = m_hold_o;
    @(posedge clk);
    if (!rstn) begin
      mdl_owner = -1; mdl_ptr = 0; mdl_run = 0; p_valid = 0;
    end else if (g >= 0) begin
      mdl_run = (g == mdl_owner) ? mdl_run + 1 : 1;
      mdl_owner = g;
      mdl_ptr = (g + 1) % NM;
      p_valid = 1; p_master = g; p_err = !hit; p_slave = sel; p_addr = m_addr_i[g];
    end else begin
      mdl_owner = -1; mdl_run = 0; p_valid = 0;
    end
    #1;
  endtask

  task automatic set_all_addr(input logic [31:0] a);
    for (int m = 0; m < NM; m++) m_addr_i[m] = a;
  endtask

  task automatic rand_inputs();
    for (int m = 0; m < NM; m++) begin
      m_req_i[m]   = ($urandom_range(0, 99) < 60);
      m_we_i[m]    = 1'($urandom_range(0, 1));
      m_addr_i[m]  = $urandom();
      m_wdata_i[m] = $urandom();
    end
  endtask

  int streak1, streak3, worst;

  initial begin
    rstn = 1'b0;
    m_req_i = '0; m_we_i = '0; m_addr_i = '0; m_wdata_i = '0;
    // Reset state, including requests present while in reset
    step();
    m_req_i = 4'b1111;
    step();
    m_req_i = '0;
    rstn = 1'b1;

    // Masters 0 and 2 read 0x10 together; 0 wins, then 2
    set_all_addr(32'h0000_0010);
    m_req_i = 4'b0101;
    step();
    m_req_i = 4'b0100;
    step();
    m_req_i = 4'b0000;
    step();

    // Masters 1 and 3 request continuously: bursts of MAX_BURST alternate
    m_req_i = 4'b1010;
    streak1 = 0; streak3 = 0; worst = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      streak1 = last_hold[1] ? streak1 + 1 : 0;
      streak3 = last_hold[3] ? streak3 + 1 : 0;
      if (streak1 > worst) worst = streak1;
      if (streak3 > worst) worst = streak3;
    end
    compared++;
    assert (worst <= MAX_BURST && worst > 0) else begin
      mismatched++;
      $error("FAIL hold_streak: observed %0d expected 1..%0d", worst, MAX_BURST);
    end

    // Master 1 alone: granted every cycle with no bubble
    m_req_i = 4'b0010;
    for (int c = 0; c < 10; c++) step();
    m_req_i = '0;
    step();

    // Master 0 writes 0x12345678 to 0x1004 (slave 1)
    m_addr_i[0] = 32'h0000_1004; m_wdata_i[0] = 32'h1234_5678; m_we_i[0] = 1'b1;
    m_req_i = 4'b0001;
    step();
    m_req_i = '0; m_we_i = '0;
    step();

    // Master 3 reads 0x3000: decode error, one-cycle error strobe
    m_addr_i[3] = 32'h0000_3000;
    m_req_i = 4'b1000;
    step();
    m_req_i = '0;
    step();
    step();

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      rand_inputs();
      step();
    end

    // Read accepted, then reset during the response cycle
    m_req_i = '0; m_we_i = '0;
    step();
    set_all_addr(32'h0000_2000);
    m_req_i = 4'b0100;
    step();
    rstn = 1'b0;
    m_req_i = 4'b0101;
    step();
    step();
    rstn = 1'b1;
    step();
    step();
    m_req_i = '0;
    step();

    // More random traffic after reset
    for (int c = 0; c < 200; c++) begin
      rand_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nib_rr_arbiter.md
Name: nib_rr_arbiter

Overview:
Parametrised successor to the fixed 6-master/3-slave network interface bus (NIB) in the multi-core SoC. It connects NUM_MASTERS core ports to NUM_SLAVES memory-mapped slaves over a single shared bus. Arbitration is round-robin with a bounded burst, so a busy core cannot starve the others. Slaves are selected by an address-field decode, an out-of-range address reports an error, and read responses are routed back with one-cycle latency.

Parameters:
NUM_MASTERS, 4, number of master ports (2..8)
NUM_SLAVES, 3, number of slave ports (1..2**SEL_W)
AW, 32, address width
DW, 32, data width
SEL_LSB, 12, lowest address bit of the slave-select field
SEL_W, 2, width of the slave-select field
MAX_BURST, 4, maximum consecutive accepted cycles per owner while another master is waiting (>=1)
ERR_DATA, 32'hDEAD_BEEF, read data returned on a decode error

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
m_req_i  in  NUM_MASTERS  per-master access request
m_addr_i  in  NUM_MASTERS x AW  per-master address
m_we_i  in  NUM_MASTERS  per-master write enable
m_wdata_i  in  NUM_MASTERS x DW  per-master write data
m_hold_o  out  NUM_MASTERS  request not accepted this cycle; master must stall and hold its request
m_rd_data_o  out  NUM_MASTERS x DW  read data, valid when m_rd_valid_o is high
m_rd_valid_o  out  NUM_MASTERS  one-cycle response strobe for the master accepted in the previous cycle
m_err_o  out  NUM_MASTERS  one-cycle decode-error strobe, aligned with m_rd_valid_o
s_req_o  out  NUM_SLAVES  one-hot slave select
s_addr_o  out  AW  shared address, from the granted master
s_we_o  out  NUM_SLAVES  per-slave write enable (s_req_o & granted we)
s_wdata_o  out  DW  shared write data
s_rd_data_i  in  NUM_SLAVES x DW  slave read data, one cycle after the request

Behaviour:
- Reset (asynchronous, rstn low):
  - owner_q = none, rr_ptr_q = 0, burst_cnt_q = 0, rsp_valid_q = 0.
  - All outputs are 0; m_hold_o = 0.
- Grant decision (combinational, per cycle), FSM state IDLE (owner_q none) / OWNED:
  - Keep the owner if m_req_i[owner_q] is high AND (burst_cnt_q < MAX_BURST-1 OR no other master is requesting).
  - Otherwise grant the first requesting master scanning rr_ptr_q, rr_ptr_q+1, ... modulo NUM_MASTERS.
  - No request → grant none, next state IDLE.
- Register update on each accepted cycle:
  - owner_q <= grant.
  - rr_ptr_q <= (grant+1) mod NUM_MASTERS.
  - burst_cnt_q increments if grant == owner_q (saturating at MAX_BURST-1), otherwise <= 0.
  - Idle cycle: owner_q <= none, burst_cnt_q <= 0, rr_ptr_q unchanged.
- m_hold_o[i] = m_req_i[i] & (grant != i), same cycle, combinational.
- Decode:
  - sel = m_addr_i[grant][SEL_LSB +: SEL_W].
  - sel < NUM_SLAVES → s_req_o[sel] = 1. Address, write enable and write data come from the granted master.
  - sel >= NUM_SLAVES → no s_req_o asserted; the access is still accepted and flagged as an error.
- Writes complete in the accept cycle. Every accepted access (read or write) produces a response in cycle t+1:
  - rsp_master_q, rsp_slave_q, rsp_err_q, rsp_valid_q are registered at t.
  - At t+1: m_rd_valid_o[rsp_master_q] = 1.
  - m_rd_data_o[rsp_master_q] = rsp_err_q ? ERR_DATA : s_rd_data_i[rsp_slave_q].
  - m_err_o[rsp_master_q] = rsp_err_q.
  - m_rd_data_o is 0 for every non-responding master.
- Back-to-back accepts from different masters are legal; the registered response routing keeps each response with its own master.
- Simultaneous requests after reset: master 0 wins.
- A master that drops m_req_i mid-burst loses ownership immediately, with no bubble if another master is requesting.
- Reset asserted mid-transaction: the pending response is discarded (no m_rd_valid_o pulse after reset release).
- No combinational path from s_rd_data_i to any s_* output.

Test Plan:
- Masters 0 and 2 both request reads at 0x0000_0010 from reset → cycle 0: grant 0, m_hold_o = 4'b0100. Cycle 1: m_rd_valid_o[0] with RAM data, grant 2. Cycle 2: m_rd_valid_o[2].
- Masters 1 and 3 request continuously (MAX_BURST=4) → grant sequence 1,1,1,1,3,3,3,3,1…; the waiting master's m_hold_o stays high for at most 4 consecutive cycles.
- Master 1 alone requests continuously for 10 cycles → granted every cycle, burst_cnt saturates at 3, no bubble.
- Master 0 writes 0x1234_5678 to 0x0000_1004 → s_req_o = 3'b010, s_we_o[1] = 1, s_addr_o = 0x1004, s_wdata_o = 0x12345678. Next cycle: m_rd_valid_o[0] = 1, m_err_o[0] = 0.
- Master 3 reads 0x0000_3000 (sel = 3 >= NUM_SLAVES) → s_req_o = 0. Next cycle: m_rd_data_o[3] = 0xDEADBEEF, m_err_o[3] = 1 for exactly one cycle.
- Read accepted, then rstn pulsed low in the response cycle → all outputs 0 during reset. After release, no m_rd_valid_o pulse, and master 0 has priority again.
